// File: rtl/array_div_sequential.sv
// Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned divisor,
// one quotient bit per clock, MSB first, with an explicit divide-by-zero result.
module array_div_sequential (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state;
    logic [7:0] dvd_r;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [3:0] dvs_r;
    logic [4:0] prem;
    logic [2:0] count;

    logic [4:0] shifted;
    logic [4:0] diff;
    logic       fits;
    logic [4:0] next_rem;

    always_comb begin
        shifted  = {prem[3:0], dvd_r[7]};
        diff     = shifted - {1'b0, dvs_r};
        fits     = (shifted >= {1'b0, dvs_r});
        next_rem = fits ? diff : shifted;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            dvd_r       <= 8'd0;
            dvs_r       <= 4'd0;
            prem        <= 5'd0;
            count       <= 3'd0;
            quotient    <= 8'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                        prem  <= 5'd0;
                        count <= 3'd7;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (dvs_r == 4'd0) begin
                        // Zero divisor bypasses the iteration with a saturated result.
                        quotient    <= 8'hFF;
                        remainder   <= 4'hF;
                        div_by_zero <= 1'b1;
                        count       <= 3'd0;
                        state       <= ST_DONE;
                    end else begin
                        prem  <= next_rem;
                        dvd_r <= {dvd_r[6:0], fits};
                        if (count == 3'd0) begin
                            quotient    <= {dvd_r[6:0], fits};
                            remainder   <= next_rem[3:0];
                            div_by_zero <= 1'b0;
                            state       <= ST_DONE;
                        end else begin
                            count <= count - 3'd1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
